// File: rtl/pipe_pkg.sv
// Shared types and defaults for the fetch stage and its IF/ID register.
package pipe_pkg;

    localparam logic [31:0] PIPE_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] PIPE_NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/pipe_fetch_reg.sv
// IF/ID pipeline register: flush beats stall, wrong-path fetches become bubbles.
module pipe_fetch_reg
    import pipe_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = PIPE_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_flush,
    input  logic        i_stall,
    input  logic        i_wrong_path,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output if_id_t      o_if_id
);

    if_id_t r_if_id;
    if_id_t w_next;

    always_comb begin
        w_next = r_if_id;
        if (i_flush) begin
            w_next.instr    = NOP_INSTR;
            w_next.pc       = '0;
            w_next.pc_plus4 = '0;
            w_next.valid    = 1'b0;
        end else if (!i_stall) begin
            // Wrong-path entries keep their PC so decode still sees a coherent address.
            w_next.instr    = i_wrong_path ? NOP_INSTR : i_instr;
            w_next.pc       = i_pc;
            w_next.pc_plus4 = pc_inc(i_pc);
            w_next.valid    = !i_wrong_path;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_id.instr    <= NOP_INSTR;
            r_if_id.pc       <= '0;
            r_if_id.pc_plus4 <= '0;
            r_if_id.valid    <= 1'b0;
        end else begin
            r_if_id <= w_next;
        end
    end

    assign o_if_id = r_if_id;

endmodule

// File: rtl/pipe_fetch.sv
// Fetch stage: owns the PC, defers redirects that arrive during stall_f, feeds IF/ID.
module pipe_fetch
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = PIPE_RESET_PC,
    parameter logic [31:0] NOP_INSTR = PIPE_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        pc_src_e,
    input  logic [31:0] pc_target_e,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d
);

    fetch_state_t r_state;
    fetch_state_t w_next_state;
    logic [31:0]  r_pc;
    logic [31:0]  w_next_pc;
    logic [31:0]  r_pend_target;
    logic [31:0]  w_next_pend;
    logic         w_wrong_path;
    if_id_t       w_if_id;

    always_comb begin
        w_next_state = r_state;
        w_next_pc    = pc_inc(r_pc);
        w_next_pend  = r_pend_target;
        if (stall_f) begin
            // Hold the PC but remember the latest redirect for when the stall lifts.
            w_next_pc = r_pc;
            if (pc_src_e) begin
                w_next_pend  = pc_target_e;
                w_next_state = PEND;
            end
        end else if (pc_src_e) begin
            w_next_pc    = pc_target_e;
            w_next_state = RUN;
        end else if (r_state == PEND) begin
            w_next_pc    = r_pend_target;
            w_next_state = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= RUN;
            r_pc          <= RESET_PC;
            r_pend_target <= '0;
        end else begin
            r_state       <= w_next_state;
            r_pc          <= w_next_pc;
            r_pend_target <= w_next_pend;
        end
    end

    assign w_wrong_path = (r_state == PEND) || pc_src_e;

    pipe_fetch_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk          (clk),
        .rst_n        (rst),
        .i_flush      (flush_d),
        .i_stall      (stall_d),
        .i_wrong_path (w_wrong_path),
        .i_instr      (imem_rdata),
        .i_pc         (r_pc),
        .o_if_id      (w_if_id)
    );

    assign pc_f       = r_pc;
    assign imem_addr  = r_pc;
    assign instr_d    = w_if_id.instr;
    assign pc_d       = w_if_id.pc;
    assign pc_plus4_d = w_if_id.pc_plus4;
    assign valid_d    = w_if_id.valid;

endmodule

// File: doc/pipe_fetch.md
Name: pipe_fetch

Overview:
Fetch stage plus IF/ID pipeline register, sitting directly upstream of the decode stage. It owns the program counter, drives the combinational instruction-memory address, and registers instruction, PC and PC+4 into decode. It handles hazard-unit stall/flush and execute-stage redirects, including redirects that arrive while fetch is stalled.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) inserted on flush or wrong-path fetch.

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous, active-low reset (0 = reset)
stall_f  in  1  hazard unit: hold PC
stall_d  in  1  hazard unit: hold IF/ID register
flush_d  in  1  hazard unit: bubble IF/ID register
pc_src_e  in  1  execute stage: taken branch/jump redirect
pc_target_e  in  32  redirect target, used unmodified
imem_rdata  in  32  instruction word at imem_addr, combinational
imem_addr  out  32  equals pc_f
pc_f  out  32  current fetch PC
instr_d  out  32  registered instruction to decode
pc_d  out  32  registered PC of instr_d
pc_plus4_d  out  32  registered pc_d+4
valid_d  out  1  instr_d is a real, correct-path instruction

Behaviour:
- Reset (rst=0, async, immediate): pc_f=RESET_PC, instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0, pend_target=0, state RUN. Reset mid-operation discards any pending redirect.
- FSM states: RUN (normal), PEND (redirect captured during stall_f, not yet applied).
- PC next-value priority, evaluated each posedge:
  1. stall_f=1: pc_f holds. If pc_src_e=1, pend_target<=pc_target_e and state->PEND. A second redirect while in PEND overwrites pend_target (latest wins).
  2. stall_f=0, pc_src_e=1: pc_f<=pc_target_e, state->RUN; a live redirect overrides any pending one.
  3. stall_f=0, state PEND: pc_f<=pend_target, state->RUN.
  4. Otherwise pc_f<=pc_f+4.
- PC+4 arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4=32'h0000_0000; no overflow flag. No alignment check.
- IF/ID register priority:
  1. flush_d=1: instr_d<=NOP_INSTR, pc_d<=0, pc_plus4_d<=0, valid_d<=0. Flush beats stall_d.
  2. stall_d=1: all IF/ID outputs hold.
  3. Wrong-path capture: state PEND, or pc_src_e=1 this cycle. Load instr_d<=NOP_INSTR and valid_d<=0, with pc_d/pc_plus4_d loaded as normal.
  4. Else instr_d<=imem_rdata, pc_d<=pc_f, pc_plus4_d<=pc_f+4, valid_d<=1.
- Latency: an instruction at PC X appears on instr_d one cycle after pc_f=X. After a redirect is applied, the target instruction reaches decode one cycle later.
- Simultaneous stall_f=0, stall_d=1: pc_f advances and that fetch is lost. The hazard unit must assert the stalls together; this block does not check it.
- imem_addr is combinational from pc_f and has no registered delay.

Decomposition:
- Shared package pipe_pkg holds:
  - the NOP_INSTR and RESET_PC default constants;
  - fetch_state_t enum {RUN, PEND};
  - if_id_t packed struct {instr, pc, pc_plus4, valid}.
- One natural sub-module, pipe_fetch_reg: the IF/ID register with flush/stall/bubble priority. The PC logic and FSM stay in pipe_fetch.

Test Plan:
- Release reset, imem word@0=0x00500093 -> pc_f 0,4,8 on successive cycles; one cycle after release instr_d=0x00500093, pc_d=0, pc_plus4_d=4, valid_d=1.
- At pc_f=0x8, hold stall_f=stall_d=1 for 3 cycles -> pc_f stays 0x8 and instr_d/pc_d (0x4) are unchanged; after release pc_f=0xC and pc_d=0x8.
- pc_src_e=1, pc_target_e=0x100, flush_d=1 -> next cycle pc_f=0x100, instr_d=0x13, valid_d=0; following cycle pc_d=0x100, valid_d=1.
- pc_src_e=1, target=0x40 while stall_f=stall_d=1 for 2 cycles -> pc_f holds and state=PEND. On release pc_f=0x40, and the captured wrong-path entry has valid_d=0, instr_d=0x13.
- RESET_PC=32'hFFFF_FFF8 -> pc_f FFFF_FFF8, FFFF_FFFC, 0000_0000; the entry with pc_d=FFFF_FFFC has pc_plus4_d=0.
- Drive rst=0 mid-cycle while in PEND -> all outputs reset immediately without a clock edge. After release, pc_f=RESET_PC and the pending target is never applied.
